// File: rtl/wb_stage.sv
// RV64 write-back stage: result select, load align, load-latency FSM.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int          XLEN   = 64,
  parameter logic [6:0]  NOP_OP = 7'b0010011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_func3,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            stall,
  output logic [XLEN-1:0] wdata,
  output logic [4:0]      wrd,
  output logic [6:0]      wopcode,
  output logic            wb_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  logic [0:0] state, nxt_state;
  logic [2:0] hold_f3, hold_off;
  logic [4:0] hold_rd;
  logic [6:0] hold_op;

  logic            capture, retire;
  logic [6:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data, sel;
  logic            is_load, is_link, is_lui, no_rd;

  function automatic logic [XLEN-1:0] align(
    input logic [XLEN-1:0] d,
    input logic [2:0]      off,
    input logic [2:0]      f3
  );
    logic [XLEN-1:0] v;
    v = d >> {off, 3'b000};
    case (f3)
      3'b000:  align = {{(XLEN-8){v[7]}}, v[7:0]};
      3'b001:  align = {{(XLEN-16){v[15]}}, v[15:0]};
      3'b010:  align = {{(XLEN-32){v[31]}}, v[31:0]};
      3'b011:  align = v;
      3'b100:  align = {{(XLEN-8){1'b0}}, v[7:0]};
      3'b101:  align = {{(XLEN-16){1'b0}}, v[15:0]};
      3'b110:  align = {{(XLEN-32){1'b0}}, v[31:0]};
      default: align = '0;
    endcase
  endfunction

  assign is_load = (in_opcode == OP_LOAD);
  assign is_link = (in_opcode == OP_JAL) || (in_opcode == OP_JALR);
  assign is_lui  = (in_opcode == OP_LUI);
  assign no_rd   = (in_opcode == OP_STORE) || (in_opcode == OP_BRANCH);

  always_comb begin
    sel = in_alu_result;
    unique case (1'b1)
      is_load: sel = align(mem_rdata, in_alu_result[2:0], in_func3);
      is_link: sel = in_pc + 64'd4;
      is_lui:  sel = in_imm;
      default: sel = in_alu_result;
    endcase
  end

  always_comb begin
    nxt_state = state;
    capture   = 1'b0;
    retire    = 1'b0;
    r_op      = NOP_OP;
    r_rd      = 5'd0;
    r_data    = '0;
    case (state)
      RUN: begin
        if (in_valid) begin
          if (is_load && !mem_rvalid) begin
            capture   = 1'b1;
            nxt_state = LOAD_WAIT;
          end else begin
            retire = 1'b1;
            r_op   = in_opcode;
            r_rd   = no_rd ? 5'd0 : in_rd;
            r_data = sel;
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          retire    = 1'b1;
          r_op      = hold_op;
          r_rd      = hold_rd;
          r_data    = align(mem_rdata, hold_off, hold_f3);
          nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      stall    <= 1'b0;
      wdata    <= '0;
      wrd      <= 5'd0;
      wopcode  <= NOP_OP;
      wb_valid <= 1'b0;
      hold_f3  <= 3'd0;
      hold_off <= 3'd0;
      hold_rd  <= 5'd0;
      hold_op  <= 7'd0;
    end else begin
      state    <= nxt_state;
      stall    <= (nxt_state == LOAD_WAIT);
      // x0 must never see a non-zero value, even on the forward path
      wdata    <= (retire && r_rd != 5'd0) ? r_data : '0;
      wrd      <= retire ? r_rd : 5'd0;
      wopcode  <= retire ? r_op : NOP_OP;
      wb_valid <= retire;
      if (capture) begin
        hold_f3  <= in_func3;
        hold_off <= in_alu_result[2:0];
        hold_rd  <= in_rd;
        hold_op  <= in_opcode;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retire_count <= 64'd0;
    else if (retire)
      retire_count <= retire_count + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a behavioural model.
// Directed cases pin the model with hand-computed literals.
module tb_wb_stage;
  localparam logic [6:0] NOP = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] ADD = 7'b0110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, mem_rvalid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [4:0]  in_rd;
  logic [63:0] in_alu_result, in_pc, in_imm, mem_rdata;
  logic        stall, wb_valid;
  logic [63:0] wdata;
  logic [4:0]  wrd;
  logic [6:0]  wopcode;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_imm(in_imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .stall(stall), .wdata(wdata), .wrd(wrd),
    .wopcode(wopcode), .wb_valid(wb_valid)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: a pending load, if any
  bit          m_wait;
  logic [2:0]  m_f3, m_off;
  logic [4:0]  m_rd;
  logic [6:0]  m_op;
  logic [63:0] e_wdata, e_cnt;
  logic [4:0]  e_wrd;
  logic [6:0]  e_wop;
  logic        e_wbv, e_stall;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // byte-wise load extraction; bytes past the doubleword read as 0
  function automatic logic [63:0] ld_val(input logic [63:0] d,
      input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] r;
    logic [7:0]  b;
    logic        sgn;
    int          nb, j;
    if (f3 == 3'b111) return 64'd0;
    nb  = 1 << f3[1:0];
    r   = 64'd0;
    sgn = 1'b0;
    for (int i = 0; i < nb; i++) begin
      j = int'(off) + i;
      b = (j < 8) ? d[8*(j%8) +: 8] : 8'h00;
      r[8*i +: 8] = b;
      sgn = b[7];
    end
    if (!f3[2] && sgn)
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic m_retire(input logic [6:0] op, input logic [4:0] rd,
                          input logic [63:0] res);
    e_wbv   = 1'b1;
    e_wop   = op;
    e_wrd   = rd;
    e_wdata = (rd == 5'd0) ? 64'd0 : res;
    e_cnt   = e_cnt + 64'd1;
  endtask

  task automatic step(input logic r, input logic v, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
      input logic [63:0] pc, input logic [63:0] imm,
      input logic [63:0] md, input logic mv);
    logic [63:0] res;
    rst = r; in_valid = v; in_opcode = op; in_func3 = f3; in_rd = rd;
    in_alu_result = alu; in_pc = pc; in_imm = imm;
    mem_rdata = md; mem_rvalid = mv;
    e_wdata = 64'd0; e_wrd = 5'd0; e_wop = NOP; e_wbv = 1'b0;
    if (r) begin
      m_wait = 1'b0;
      e_cnt  = 64'd0;
    end else if (m_wait) begin
      if (mv) begin
        m_retire(m_op, m_rd, ld_val(md, m_off, m_f3));
        m_wait = 1'b0;
      end
    end else if (v) begin
      if (op == LD && !mv) begin
        m_wait = 1'b1;
        m_f3 = f3; m_off = alu[2:0]; m_rd = rd; m_op = op;
      end else begin
        if (op == LD)                  res = ld_val(md, alu[2:0], f3);
        else if (op == JAL || op == JR) res = pc + 64'd4;
        else if (op == LUI)            res = imm;
        else                           res = alu;
        m_retire(op, (op == ST || op == BR) ? 5'd0 : rd, res);
      end
    end
    e_stall = m_wait;
    @(posedge clk);
    #1;
    chk("stall", {63'd0, stall}, {63'd0, e_stall});
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, e_wbv});
    chk("wrd", {59'd0, wrd}, {59'd0, e_wrd});
    chk("wopcode", {57'd0, wopcode}, {57'd0, e_wop});
    chk("wdata", wdata, e_wdata);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_count", retire_count, e_cnt);
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, ADD, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
  endtask

  logic [63:0] md0;
  logic [6:0]  ops [8];
  int          nstall;

  initial begin
    md0 = 64'hDEADBEEF_00000080;
    ops[0] = LD; ops[1] = JAL; ops[2] = JR; ops[3] = LUI;
    ops[4] = ST; ops[5] = BR;  ops[6] = ADD; ops[7] = NOP;
    m_wait = 1'b0; e_cnt = 64'd0;
    @(negedge clk);

    // reset for two cycles
    step(1'b1, 1'b0, ADD, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    step(1'b1, 1'b0, ADD, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    chk("rst_wopcode", {57'd0, wopcode}, 64'h13);
    chk("rst_stall", {63'd0, stall}, 64'd0);

    step(1'b0, 1'b1, ADD, 3'd0, 5'd5, 64'h1234, 64'd0, 64'd0, 64'd0, 1'b0);
    chk("add_wrd", {59'd0, wrd}, 64'd5);
    chk("add_wdata", wdata, 64'h1234);

    step(1'b0, 1'b1, LD, 3'b000, 5'd3, 64'h1000, 64'd0, 64'd0, md0, 1'b1);
    chk("lb", wdata, 64'hFFFF_FFFF_FFFF_FF80);
    step(1'b0, 1'b1, LD, 3'b100, 5'd3, 64'h1000, 64'd0, 64'd0, md0, 1'b1);
    chk("lbu", wdata, 64'h80);
    step(1'b0, 1'b1, LD, 3'b010, 5'd3, 64'h1004, 64'd0, 64'd0, md0, 1'b1);
    chk("lw", wdata, 64'hFFFF_FFFF_DEAD_BEEF);
    step(1'b0, 1'b1, LD, 3'b110, 5'd3, 64'h1004, 64'd0, 64'd0, md0, 1'b1);
    chk("lwu", wdata, 64'h0000_0000_DEAD_BEEF);

    // LD with rvalid three cycles after presentation
    nstall = 0;
    step(1'b0, 1'b1, LD, 3'b011, 5'd9, 64'h2000, 64'd0, 64'd0, 64'd0, 1'b0);
    nstall += int'(stall);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, ADD, 3'd0, 5'd4, 64'h77, 64'd0, 64'd0, 64'd0, 1'b0);
      nstall += int'(stall);
    end
    step(1'b0, 1'b1, ADD, 3'd0, 5'd4, 64'h77, 64'd0, 64'd0,
         64'h0123_4567_89AB_CDEF, 1'b1);
    chk("ld_stall_cycles", 64'(nstall), 64'd3);
    chk("ld_wrd", {59'd0, wrd}, 64'd9);
    chk("ld_wdata", wdata, 64'h0123_4567_89AB_CDEF);
    chk("ld_stall_end", {63'd0, stall}, 64'd0);

    step(1'b0, 1'b1, JAL, 3'd0, 5'd1, 64'd0, 64'h100, 64'd0, 64'd0, 1'b0);
    chk("jal", wdata, 64'h104);
    step(1'b0, 1'b1, ST, 3'd3, 5'd7, 64'h55, 64'd0, 64'd0, 64'd0, 1'b1);
    chk("sw_wrd", {59'd0, wrd}, 64'd0);
    chk("sw_valid", {63'd0, wb_valid}, 64'd1);
    step(1'b0, 1'b1, NOP, 3'd0, 5'd0, 64'd5, 64'd0, 64'd0, 64'd0, 1'b0);
    chk("addi_x0", wdata, 64'd0);

    // reset while a load is outstanding
    step(1'b0, 1'b1, LD, 3'b011, 5'd9, 64'h2000, 64'd0, 64'd0, 64'd0, 1'b0);
    step(1'b1, 1'b0, ADD, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'hFF, 1'b1);
    chk("rst_lw_stall", {63'd0, stall}, 64'd0);
    chk("rst_lw_valid", {63'd0, wb_valid}, 64'd0);
    step(1'b0, 1'b0, ADD, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'hFF, 1'b1);
    chk("rst_lw_after", {63'd0, wb_valid}, 64'd0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, ADD, 3'd0, 5'(i + 1), 64'(i), 64'd0, 64'd0,
           64'd0, 1'b0);
    idle();
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_four", retire_count, 64'd4);
`endif

    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), op, 3'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 9) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
